// File: rtl/fft_result_serializer.sv
// Shadow-buffers one FFT result frame on i_capture and streams it byte by byte
// into a UART transmitter over a start/done handshake.
module fft_result_serializer #(
    parameter int POINTS      = 32,
    parameter int WORD_SIZE   = 16,
    parameter int DATA_LENGTH = 8,
    parameter int SEND_IM     = 0,
    parameter int MSB_FIRST   = 0,
    parameter int HEADER_EN   = 1,
    parameter logic [DATA_LENGTH-1:0] HEADER_BYTE = 8'hA5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_capture,
    input  logic [POINTS*WORD_SIZE-1:0]   i_re_flat,
    input  logic [POINTS*WORD_SIZE-1:0]   i_im_flat,
    input  logic                          i_abort,
    input  logic                          i_tx_done,
    output logic                          o_tx_start,
    output logic [DATA_LENGTH-1:0]        o_tx_byte,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_overrun,
    output logic [1:0]                    dbg_state
);

    // Handshake: o_tx_start is a one-cycle request carrying o_tx_byte; the
    // transmitter answers with a one-cycle i_tx_done, honoured only in WAIT.
    localparam int BPW    = (WORD_SIZE + DATA_LENGTH - 1) / DATA_LENGTH;
    localparam int COMP   = 1 + SEND_IM;
    localparam int NBYTES = HEADER_EN + POINTS * COMP * BPW;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int EW     = BPW * DATA_LENGTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                        state;
    logic [IW-1:0]                 idx;
    logic [POINTS*WORD_SIZE-1:0]   re_buf;
    logic [POINTS*WORD_SIZE-1:0]   im_buf;

    logic [IW-1:0]                 nxt_idx;
    logic [DATA_LENGTH-1:0]        nxt_byte;
    logic [POINTS*WORD_SIZE-1:0]   re_src;
    logic [POINTS*WORD_SIZE-1:0]   im_src;
    logic signed [WORD_SIZE-1:0]   word_s;
    logic signed [EW-1:0]          word_ext;
    logic                          accept;
    logic                          last;
    int                            pos;
    int                            word_n;
    int                            bin;
    int                            sub;
    int                            lane;

    assign dbg_state = state;
    // The cycle o_frame_done is high still counts as part of the old frame.
    assign accept    = (state == S_IDLE) && !o_frame_done && i_capture;
    assign last      = (idx == IW'(NBYTES - 1));

    // Byte for the index entered on the next SEND; from IDLE the frame is
    // being latched this edge, so it is read straight off the input buses.
    always_comb begin
        nxt_idx  = (state == S_IDLE) ? '0 : idx + IW'(1);
        re_src   = (state == S_IDLE) ? i_re_flat : re_buf;
        im_src   = (state == S_IDLE) ? i_im_flat : im_buf;
        pos      = int'(nxt_idx) - HEADER_EN;
        word_n   = (pos < 0) ? 0 : pos / BPW;
        lane     = (pos < 0) ? 0 : pos % BPW;
        sub      = word_n % COMP;
        bin      = word_n / COMP;
        if (bin >= POINTS) bin = 0;
        if (MSB_FIRST != 0) lane = BPW - 1 - lane;
        word_s   = (sub != 0) ? im_src[bin*WORD_SIZE +: WORD_SIZE]
                              : re_src[bin*WORD_SIZE +: WORD_SIZE];
        word_ext = EW'(word_s);
        nxt_byte = word_ext[lane*DATA_LENGTH +: DATA_LENGTH];
        if (HEADER_EN != 0 && nxt_idx == '0) nxt_byte = HEADER_BYTE;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            re_buf       <= '0;
            im_buf       <= '0;
            o_tx_start   <= 1'b0;
            o_tx_byte    <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            o_tx_start   <= 1'b0;
            if (i_capture && !accept) o_overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        re_buf     <= i_re_flat;
                        im_buf     <= i_im_flat;
                        idx        <= '0;
                        o_tx_byte  <= nxt_byte;
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_abort) begin
                        idx    <= '0;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        idx    <= '0;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else if (i_tx_done) begin
                        if (last) begin
                            idx          <= '0;
                            o_busy       <= 1'b0;
                            o_frame_done <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            idx        <= nxt_idx;
                            o_tx_byte  <= nxt_byte;
                            o_tx_start <= 1'b1;
                            state      <= S_SEND;
                        end
                    end
                end
                default: begin
                    idx    <= '0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_serializer.sv
// Directed bench: a default-parameter serializer plus a 4-bin, 12-bit,
// imaginary-enabled, MSB-first, headerless instance.
module tb_fft_result_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_cap = 0, a_abort = 0, a_done = 0;
    logic [511:0] a_re = '0, a_im = '0;
    logic         a_start, a_busy, a_fdone, a_ovr;
    logic [7:0]   a_byte;
    logic [1:0]   a_state;

    logic         b_cap = 0, b_done = 0;
    logic [47:0]  b_re = '0, b_im = '0;
    logic         b_start, b_busy, b_fdone, b_ovr;
    logic [7:0]   b_byte;
    logic [1:0]   b_state;

    fft_result_serializer dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_capture(a_cap), .i_re_flat(a_re),
        .i_im_flat(a_im), .i_abort(a_abort), .i_tx_done(a_done),
        .o_tx_start(a_start), .o_tx_byte(a_byte), .o_busy(a_busy),
        .o_frame_done(a_fdone), .o_overrun(a_ovr), .dbg_state(a_state)
    );

    fft_result_serializer #(
        .POINTS(4), .WORD_SIZE(12), .DATA_LENGTH(8), .SEND_IM(1),
        .MSB_FIRST(1), .HEADER_EN(0), .HEADER_BYTE(8'hA5)
    ) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_capture(b_cap), .i_re_flat(b_re),
        .i_im_flat(b_im), .i_abort(1'b0), .i_tx_done(b_done),
        .o_tx_start(b_start), .o_tx_byte(b_byte), .o_busy(b_busy),
        .o_frame_done(b_fdone), .o_overrun(b_ovr), .dbg_state(b_state)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_a();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back(a_re[k*16 +: 8]);
            exp_q.push_back(a_re[k*16+8 +: 8]);
        end
    endtask

    task automatic cap(input bit sel);
        @(negedge clk);
        if (sel) b_cap = 1'b1; else a_cap = 1'b1;
        @(negedge clk);
        a_cap = 1'b0;
        b_cap = 1'b0;
    endtask

    // Waits for a start pulse, checks the byte, answers with done 5 cycles on.
    task automatic serve(input bit sel, input int n, input int cap_at);
        int wcnt;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            wcnt = 0;
            while (!(sel ? b_start : a_start) && wcnt < 50) begin
                @(negedge clk);
                wcnt++;
            end
            chk("start_seen", {31'd0, sel ? b_start : a_start}, 32'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("tx_byte", {24'd0, sel ? b_byte : a_byte}, {24'd0, e});
            chk("busy_in_frame", {31'd0, sel ? b_busy : a_busy}, 32'd1);
            @(negedge clk);
            if (i == cap_at) begin
                a_cap = 1'b1;
                a_re = ~a_re;
            end
            @(negedge clk);
            a_cap = 1'b0;
            chk("start_one_cycle", {31'd0, sel ? b_start : a_start}, 32'd0);
            repeat (3) @(negedge clk);
            chk("byte_hold", {24'd0, sel ? b_byte : a_byte}, {24'd0, e});
            if (sel) b_done = 1'b1; else a_done = 1'b1;
            @(negedge clk);
            a_done = 1'b0;
            b_done = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        for (int k = 0; k < 32; k++) a_re[k*16 +: 16] = {8'(k*3 + 1), 8'(k ^ 8'h5A)};
        a_re[15:0]    = 16'h1234;
        a_re[511:496] = 16'hBEEF;
        b_re = {12'h8F0, 12'h003, 12'h002, 12'h001};
        b_im = {12'h800, 12'h7FF, 12'h0F0, 12'hFFF};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_start", {31'd0, a_start}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_fdone", {31'd0, a_fdone}, 32'd0);
        chk("rst_ovr", {31'd0, a_ovr}, 32'd0);
        chk("rst_byte", {24'd0, a_byte}, 32'd0);
        chk("rst_state", {30'd0, a_state}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // default frame: 65 bytes, header first, little-endian words
        fill_a();
        chk("hand_byte1", {24'd0, exp_q[1]}, 32'h34);
        chk("hand_byte64", {24'd0, exp_q[64]}, 32'hBE);
        cap(0);
        serve(0, 65, -1);
        chk("frame_done", {31'd0, a_fdone}, 32'd1);
        chk("busy_drop", {31'd0, a_busy}, 32'd0);
        chk("no_overrun", {31'd0, a_ovr}, 32'd0);
        @(negedge clk);
        chk("frame_done_pulse", {31'd0, a_fdone}, 32'd0);

        // headerless MSB-first frame with imaginary parts and sign extension
        exp_q.delete();
        exp_q = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'hF0,
                  8'h00, 8'h03, 8'h07, 8'hFF, 8'hF8, 8'hF0, 8'hF8, 8'h00};
        cap(1);
        serve(1, 16, -1);
        chk("b_frame_done", {31'd0, b_fdone}, 32'd1);
        chk("b_busy_drop", {31'd0, b_busy}, 32'd0);

        // capture during transmission is refused and flagged
        fill_a();
        cap(0);
        serve(0, 65, 10);
        chk("ovr_frame_done", {31'd0, a_fdone}, 32'd1);
        chk("ovr_set", {31'd0, a_ovr}, 32'd1);
        fill_a();
        chk("new_data_hi", {24'd0, exp_q[2]}, 32'hED);
        cap(0);
        serve(0, 65, -1);
        chk("ovr_frame2_done", {31'd0, a_fdone}, 32'd1);
        a_cap = 1'b1;
        @(negedge clk);
        a_cap = 1'b0;
        chk("cap_on_fdone_refused", {31'd0, a_busy}, 32'd0);
        chk("ovr_sticky", {31'd0, a_ovr}, 32'd1);

        // abort together with done at byte 20
        fill_a();
        cap(0);
        serve(0, 20, -1);
        cnt = 0;
        while (!a_start && cnt < 50) begin @(negedge clk); cnt++; end
        chk("abort_byte20", {24'd0, a_byte}, {24'd0, exp_q[0]});
        repeat (3) @(negedge clk);
        a_done = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        a_abort = 1'b0;
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        chk("abort_no_start", {31'd0, a_start}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_start || a_fdone) cnt++;
        end
        chk("abort_quiet", cnt, 32'd0);
        fill_a();
        cap(0);
        serve(0, 2, -1);

        // asynchronous reset mid-WAIT
        cnt = 0;
        while (!a_start && cnt < 50) begin @(negedge clk); cnt++; end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start", {31'd0, a_start}, 32'd0);
        chk("arst_busy", {31'd0, a_busy}, 32'd0);
        chk("arst_ovr", {31'd0, a_ovr}, 32'd0);
        chk("arst_byte", {24'd0, a_byte}, 32'd0);
        chk("arst_fdone", {31'd0, a_fdone}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_start || a_busy) cnt++;
        end
        chk("post_rst_idle", cnt, 32'd0);
        fill_a();
        cap(0);
        chk("restart_start", {31'd0, a_start}, 32'd1);
        chk("restart_header", {24'd0, a_byte}, 32'hA5);
        chk("restart_busy", {31'd0, a_busy}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
